// File: rtl/hamming_secded_pipe_decoder.sv
// Two-stage pipelined Hamming SEC-DED decoder with valid/ready flow control.
//
// Codeword layout: bit 0 is overall even parity; bits 1..N-1 are Hamming
// positions. Check bits sit at power-of-two positions. Data bits fill the
// remaining positions in ascending order, LSB first.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   in_valid/ready  input handshake; in_code is the received N-bit codeword
//   out_valid/ready output handshake
//   out_data        corrected data word
//   out_syndrome    Hamming syndrome of the word
//   out_err_single  single error corrected (or parity-bit-only error)
//   out_err_double  uncorrectable error
//   cnt_clr         synchronous clear of both error counters
//   corr_count      saturating count of single-error words
//   uncorr_count    saturating count of uncorrectable words
//
// Build option: define HAMMING_SECDED_ERR_CNT_EN to implement the error
// counters. Without it the counts read 0 and cnt_clr is ignored.
module hamming_secded_pipe_decoder #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned R      = 4,
    parameter int unsigned CNT_W  = 16,
    localparam int unsigned N     = DATA_W + R + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N-1:0]      in_code,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [R-1:0]      out_syndrome,
    output logic              out_err_single,
    output logic              out_err_double,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  corr_count,
    output logic [CNT_W-1:0]  uncorr_count
);

    localparam int unsigned KW = $clog2(DATA_W);
    // Highest valid Hamming position; larger syndromes cannot be a single error.
    localparam logic [R-1:0] MAX_POS = R'(N - 1);

    // R must be the smallest value with 2^R >= DATA_W+R+1.
    if (DATA_W < 4 || DATA_W > 64 || (2 ** R) < N || (2 ** (R - 1)) >= (DATA_W + R))
    begin : g_bad_params
        $error("hamming_secded_pipe_decoder: illegal DATA_W/R combination");
    end

    // ---------------- Flow control ----------------
    logic s1_valid_q, s1_valid_d;
    logic s2_valid_q, s2_valid_d;
    logic s1_accept, s2_accept;

    assign s2_accept = !s2_valid_q || out_ready;
    assign s1_accept = !s1_valid_q || s2_accept;
    assign in_ready  = s1_accept;
    assign out_valid = s2_valid_q;

    // ---------------- Stage 1: syndrome and parity ----------------
    logic [N-1:0] s1_code_q, s1_code_d;
    logic [R-1:0] s1_syn_q, s1_syn_d, syn_in;
    logic         s1_par_q, s1_par_d;

    always_comb begin
        syn_in = '0;
        for (int unsigned i = 1; i < N; i++) begin
            if (in_code[i]) syn_in = syn_in ^ R'(i);
        end
    end

    always_comb begin
        s1_valid_d = s1_accept ? in_valid : s1_valid_q;
        s1_code_d  = s1_code_q;
        s1_syn_d   = s1_syn_q;
        s1_par_d   = s1_par_q;
        if (s1_accept && in_valid) begin
            s1_code_d = in_code;
            s1_syn_d  = syn_in;
            s1_par_d  = ^in_code;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_code_q  <= '0;
            s1_syn_q   <= '0;
            s1_par_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_code_q  <= s1_code_d;
            s1_syn_q   <= s1_syn_d;
            s1_par_q   <= s1_par_d;
        end
    end

    // ---------------- Stage 2: classify, correct, extract ----------------
    logic [N-1:0]      fixed_code;
    logic [DATA_W-1:0] fixed_data;
    logic [KW-1:0]     k;
    logic              cls_single, cls_double;

    always_comb begin
        cls_single = 1'b0;
        cls_double = 1'b0;
        fixed_code = s1_code_q;
        if (s1_par_q) begin
            if (s1_syn_q > MAX_POS) begin
                cls_double = 1'b1;
            end else begin
                cls_single = 1'b1;
                // Syndrome 0 with odd parity means only bit 0 flipped: nothing to fix.
                if (s1_syn_q != '0) fixed_code = s1_code_q ^ (N'(1) << s1_syn_q);
            end
        end else if (s1_syn_q != '0) begin
            cls_double = 1'b1;
        end

        fixed_data = '0;
        k          = '0;
        for (int unsigned i = 1; i < N; i++) begin
            if ((i & (i - 1)) != 0) begin
                fixed_data[k] = fixed_code[i];
                k = k + 1'b1;
            end
        end
    end

    logic [DATA_W-1:0] data_q, data_d;
    logic [R-1:0]      syn_q, syn_d;
    logic              single_q, single_d, double_q, double_d;

    always_comb begin
        s2_valid_d = s2_accept ? s1_valid_q : s2_valid_q;
        data_d     = data_q;
        syn_d      = syn_q;
        single_d   = single_q;
        double_d   = double_q;
        if (s2_accept && s1_valid_q) begin
            data_d   = fixed_data;
            syn_d    = s1_syn_q;
            single_d = cls_single;
            double_d = cls_double;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            data_q     <= '0;
            syn_q      <= '0;
            single_q   <= 1'b0;
            double_q   <= 1'b0;
        end else begin
            s2_valid_q <= s2_valid_d;
            data_q     <= data_d;
            syn_q      <= syn_d;
            single_q   <= single_d;
            double_q   <= double_d;
        end
    end

    assign out_data       = data_q;
    assign out_syndrome   = syn_q;
    assign out_err_single = single_q;
    assign out_err_double = double_q;

    // ---------------- Error counters ----------------
`ifdef HAMMING_SECDED_ERR_CNT_EN
    logic [CNT_W-1:0] corr_q, corr_d, uncorr_q, uncorr_d;
    logic             out_xfer;

    assign out_xfer = s2_valid_q && out_ready;

    // Clear has priority over a coincident increment; counts saturate.
    always_comb begin
        corr_d   = corr_q;
        uncorr_d = uncorr_q;
        if (cnt_clr) begin
            corr_d   = '0;
            uncorr_d = '0;
        end else if (out_xfer) begin
            if (single_q && corr_q != '1)   corr_d   = corr_q + 1'b1;
            if (double_q && uncorr_q != '1) uncorr_d = uncorr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            corr_q   <= '0;
            uncorr_q <= '0;
        end else begin
            corr_q   <= corr_d;
            uncorr_q <= uncorr_d;
        end
    end

    assign corr_count   = corr_q;
    assign uncorr_count = uncorr_q;
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign corr_count     = '0;
    assign uncorr_count   = '0;
`endif

endmodule
